dpram_port_arbiter: RTL and testbench

//  Shares one port of a dpramv_16 dual-port RAM between NUM_REQ requesters (e.g. CPU, sprite DMA, debug).

---
 rtl/dpram_arb_pkg.sv | 15 +
 rtl/dpram_port_arbiter_rr_pick.sv | 33 +++
 rtl/dpram_port_arbiter.sv | 121 ++++++++++++
 tb/tb_dpram_port_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_arb_pkg.sv
// Shared types and helpers for the dual-port RAM port arbiter.
// Holds the FSM encoding and the one-hot check used by assertions.
package dpram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE
  } arb_state_t;

  function automatic logic onehot0(input logic [7:0] v);
    return (v & (v - 8'd1)) == 8'd0;
  endfunction

endpackage

// File: rtl/dpram_port_arbiter_rr_pick.sv
// Combinational winner search over eligible requesters.
// Round-robin starts after ptr; fixed mode scans from index 0.
module rr_pick
  import dpram_arb_pkg::*;
#(
  parameter int N = 3,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  input  logic          fixed,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] c;

  // Scan from the last candidate down so the first candidate wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    c     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      c = fixed ? IW'(k)
                : IW'((int'(ptr) + 1 + k) % N);
      if (eligible[c]) begin
        valid = 1'b1;
        idx   = c;
      end
    end
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares one RAM port among NUM_REQ requesters, one access per 3 clk.
// Level req / pulse ack; rdata carries the RAM word for the served access.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_W     = 10,
  parameter int FIXED_PRIO = 0,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [2*NUM_REQ-1:0]      req_we,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [16*NUM_REQ-1:0]     req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [15:0]               rdata,
  output logic                      busy,
  output logic [IW-1:0]             grant_idx,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [1:0]                ram_we,
  output logic [15:0]               ram_data,
  input  logic [15:0]               ram_q
);

  arb_state_t           state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        grant_q, grant_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [15:0]          rdata_q, rdata_d;
  logic [ADDR_W-1:0]    ram_addr_q, ram_addr_d;
  logic [1:0]           ram_we_q, ram_we_d;
  logic [15:0]          ram_data_q, ram_data_d;

  logic [NUM_REQ-1:0]   eligible;
  logic                 pick_valid;
  logic [IW-1:0]        pick_idx;

  // A requester is masked while its ack is out, so a held req is served once.
  assign eligible = req & ~ack_q;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .fixed    (FIXED_PRIO != 0),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    ack_d      = '0;
    rdata_d    = rdata_q;
    ram_addr_d = ram_addr_q;
    ram_we_d   = 2'b00;
    ram_data_d = ram_data_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d    = pick_idx;
          ptr_d      = pick_idx;
          ram_addr_d = req_addr[pick_idx*ADDR_W +: ADDR_W];
          ram_we_d   = req_we[pick_idx*2 +: 2];
          ram_data_d = req_data[pick_idx*16 +: 16];
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        rdata_d        = ram_q;
        ack_d[grant_q] = 1'b1;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= IW'(NUM_REQ - 1);
      grant_q    <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      ram_addr_q <= '0;
      ram_we_q   <= 2'b00;
      ram_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      ram_addr_q <= ram_addr_d;
      ram_we_q   <= ram_we_d;
      ram_data_q <= ram_data_d;
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != IDLE);
  assign grant_idx = grant_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_data  = ram_data_q;

  a_ack_onehot0: assert property (
    @(posedge clk) disable iff (reset) onehot0(8'(ack_q)));

  a_grant_range: assert property (
    @(posedge clk) int'(grant_q) < NUM_REQ);

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a byte-enabled RAM model.
// A second instance runs fixed priority alongside round-robin.
module tb_dpram_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 10;

  logic            clk = 1'b0;
  logic            reset;
  logic            preload;
  logic [N-1:0]    req, req_f;
  logic [2*N-1:0]  req_we;
  logic [AW*N-1:0] req_addr;
  logic [16*N-1:0] req_data;

  logic [N-1:0]    ack, ack_f;
  logic [15:0]     rdata, rdata_f;
  logic            busy, busy_f;
  logic [1:0]      gidx, gidx_f;
  logic [AW-1:0]   ram_addr, ram_addr_f;
  logic [1:0]      ram_we, ram_we_f;
  logic [15:0]     ram_data, ram_data_f;
  logic [15:0]     ram_q;

  logic [15:0]     mem [0:1023];
  int              we_cyc = 0;
  int              total = 0;
  int              bad = 0;

  always #5 clk = ~clk;

  dpram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .FIXED_PRIO(0)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_data(req_data), .ack(ack),
    .rdata(rdata), .busy(busy), .grant_idx(gidx),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_data(ram_data),
    .ram_q(ram_q));

  dpram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .FIXED_PRIO(1)) dut_f (
    .clk(clk), .reset(reset), .req(req_f), .req_we(req_we),
    .req_addr(req_addr), .req_data(req_data), .ack(ack_f),
    .rdata(rdata_f), .busy(busy_f), .grant_idx(gidx_f),
    .ram_addr(ram_addr_f), .ram_we(ram_we_f), .ram_data(ram_data_f),
    .ram_q(16'h0000));

  // RAM model: registered q, write-through of the merged word.
  always @(posedge clk) begin
    logic [15:0] w;
    if (preload) begin
      mem[10'h005] <= 16'hBEEF;
      mem[10'h010] <= 16'h3456;
      ram_q <= 16'h0000;
    end else begin
      w = mem[ram_addr];
      if (ram_we[0]) w[7:0] = ram_data[7:0];
      if (ram_we[1]) w[15:8] = ram_data[15:8];
      if (ram_we != 2'b00) begin
        mem[ram_addr] <= w;
        we_cyc <= we_cyc + 1;
      end
      ram_q <= w;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [1:0] we,
                         input logic [AW-1:0] a, input logic [15:0] d);
    req_we[r*2 +: 2]     = we;
    req_addr[r*AW +: AW] = a;
    req_data[r*16 +: 16] = d;
  endtask

  task automatic wait_ack(input int r, input int exp_n, input string tag);
    int n;
    n = 0;
    while (ack[r] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(n), 32'(exp_n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int acks;
    int exp_rr[6];
    int exp_fp[6];
    logic [N-1:0] e;

    exp_rr = '{0, 1, 2, 0, 1, 2};
    exp_fp = '{0, 1, 0, 1, 0, 1};
    reset = 1'b1; preload = 1'b1;
    req = '0; req_f = '0;
    req_we = '0; req_addr = '0; req_data = '0;
    tick(); tick();
    preload = 1'b0;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(gidx), 0);
    chk("rst_ram", 32'({ram_we, ram_addr, ram_data}), 0);
    reset = 1'b0;

    // 1: plain read
    base = we_cyc;
    set_req(0, 2'b00, 10'h005, 16'h0000);
    req = 3'b001;
    wait_ack(0, 3, "t1_lat");
    chk("t1_rdata", 32'(rdata), 32'hBEEF);
    req = '0;
    tick();
    chk("t1_ackoff", 32'({busy, ack}), 0);
    chk("t1_nowrite", 32'(we_cyc - base), 0);

    // 2: low-byte write then read-back
    base = we_cyc;
    set_req(1, 2'b01, 10'h010, 16'h12AB);
    req = 3'b010;
    tick();
    chk("t2_issue", 32'({ram_we, ram_addr, ram_data}),
        32'({2'b01, 10'h010, 16'h12AB}));
    tick();
    chk("t2_weoff", 32'(ram_we), 0);
    tick();
    chk("t2_ack", 32'(ack), 32'b010);
    chk("t2_rdata", 32'(rdata), 32'h34AB);
    req = '0;
    chk("t2_wecnt", 32'(we_cyc - base), 1);
    tick();
    set_req(1, 2'b00, 10'h010, 16'h0000);
    req = 3'b010;
    wait_ack(1, 3, "t2_rd_lat");
    chk("t2_rd", 32'(rdata), 32'h34AB);
    req = '0;
    tick();

    // 3: all requesting, RR vs fixed priority
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 2'b00, 10'h005, 16'h0000);
    set_req(1, 2'b00, 10'h010, 16'h0000);
    set_req(2, 2'b00, 10'h005, 16'h0000);
    req = 3'b111; req_f = 3'b111;
    for (int i = 0; i < 6; i++) begin
      for (int t = 0; t < 3; t++) begin
        tick();
        e = (t == 2) ? N'(1 << exp_rr[i]) : '0;
        chk($sformatf("t3_rr%0d_%0d", i, t), 32'(ack), 32'(e));
        e = (t == 2) ? N'(1 << exp_fp[i]) : '0;
        chk($sformatf("t3_fp%0d_%0d", i, t), 32'(ack_f), 32'(e));
      end
      chk($sformatf("t3_grr%0d", i), 32'(gidx), 32'(exp_rr[i]));
      chk($sformatf("t3_gfp%0d", i), 32'(gidx_f), 32'(exp_fp[i]));
    end
    req = '0; req_f = '0;
    tick();
    chk("t3_idle", 32'({busy, busy_f}), 0);

    // 4: held req served once; re-served only if high after ack
    set_req(2, 2'b00, 10'h005, 16'h0000);
    req = 3'b100;
    wait_ack(2, 3, "t4_lat");
    tick();
    chk("t4_masked", 32'({busy, ack}), 0);
    req = '0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ack != '0 || busy) acks++;
    end
    chk("t4_once", 32'(acks), 0);
    req = 3'b100;
    wait_ack(2, 3, "t4_lat2");
    tick();
    chk("t4_post", 32'(busy), 0);
    tick();
    chk("t4_reserve", 32'({busy, gidx}), 32'({1'b1, 2'd2}));
    req = '0;
    wait_ack(2, 2, "t4_relat");
    tick();

    // 5: reset during the ISSUE cycle of a write
    set_req(0, 2'b11, 10'h020, 16'hCAFE);
    req = 3'b001;
    tick();
    chk("t5_issue", 32'({busy, ram_we}), 32'({1'b1, 2'b11}));
    reset = 1'b1;
    req = '0;
    tick();
    chk("t5_after", 32'({busy, ack, ram_we}), 0);
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ack != '0) acks++;
    end
    chk("t5_noack", 32'(acks), 0);
    chk("t5_mem", 32'(mem[10'h020]), 32'hCAFE);

    // 6: req dropped in ISSUE; new req granted in the ack cycle
    set_req(1, 2'b00, 10'h010, 16'h0000);
    req = 3'b010;
    tick();
    req = '0;
    tick();
    tick();
    chk("t6_ack", 32'(ack), 32'b010);
    chk("t6_rdata", 32'(rdata), 32'h34AB);
    set_req(0, 2'b00, 10'h005, 16'h0000);
    req = 3'b001;
    tick();
    chk("t6_grant", 32'({busy, gidx}), 32'({1'b1, 2'd0}));
    wait_ack(0, 2, "t6_lat");
    chk("t6_rd", 32'(rdata), 32'hBEEF);
    req = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
